spi_reg_bridge: RTL and testbench
=================================

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7: register address field width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: register data width.
REQ-003 SHALL have parameter REG_COUNT, default 4: number of read/write control registers at addresses 0..REG_COUNT-1.
REQ-004 SHALL have parameter STAT_COUNT, default 2: number of read-only status words at addresses REG_COUNT..REG_COUNT+STAT_COUNT-1.
REQ-005 SHALL have parameter REG_RESET, width REG_COUNT*DATA_WIDTH, default 0: flattened reset values of the control registers.
REQ-006 SHALL have port clk_i, input, width 1: single system clock.
REQ-007 SHALL have port reset_i, input, width 1: reset, synchronous to clk_i, active-high.
REQ-008 SHALL have ports spi_sck_i, spi_sdi_i and spi_cs_i (active-low), each input, width 1: asynchronous SPI pins.
REQ-009 SHALL have port spi_sdo_o, output, width 1: SPI serial data out.
REQ-010 SHALL have port regs_o, output, width REG_COUNT*DATA_WIDTH: control register contents, register k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port wr_strobe_o, output, width REG_COUNT: one-hot pulse, one cycle long, on each register write.
REQ-012 SHALL have port status_i, input, width STAT_COUNT*DATA_WIDTH: status words, packed the same way as regs_o.
REQ-013 SHALL have port err_o, output, width 1: one-cycle pulse on an illegal access.

Function
REQ-014 SHALL pass spi_sck_i, spi_sdi_i and spi_cs_i through 2-flop synchronizers and detect sck edges in the clk_i domain; clk_i SHALL be at least 8x the sck frequency.
REQ-015 SHALL use SPI mode 0, MSB first: sdi is sampled on sck rise, sdo changes on sck fall.
REQ-016 The frame SHALL be FRAME_W = 1+ADDR_WIDTH+DATA_WIDTH bits: R/W bit (1 = read), then address, then data.
REQ-017 The FSM SHALL have states S_IDLE, S_CMD, S_DATA and S_WAIT:
- S_IDLE to S_CMD when cs is asserted.
- S_CMD to S_DATA after 1+ADDR_WIDTH bits have been sampled.
- S_DATA to S_WAIT after DATA_WIDTH further bits.
- Any state to S_IDLE when cs is deasserted.
REQ-018 On entering S_DATA for a read, the bridge SHALL snapshot the addressed word (register, status, or 0 if unmapped) and shift it out MSB first, starting at the next sck fall.
REQ-019 A write SHALL update the addressed register and pulse its wr_strobe_o bit in the clk_i cycle after the final data bit is detected.
REQ-020 A write to a status or unmapped address SHALL be ignored and SHALL pulse err_o, with the same timing as REQ-019.
REQ-021 A read of an unmapped address SHALL return 0 and SHALL pulse err_o.
REQ-022 A cs deassertion before the final data bit SHALL abort the frame: no write, no strobe, no err_o.
REQ-023 spi_sdo_o SHALL be 0 in S_IDLE, S_CMD and S_WAIT, and SHALL be held at 0 for writes.
REQ-024 A write and a read-snapshot of the same register in the same cycle SHALL return the pre-write value.

Reset
REQ-025 While reset_i is high, the FSM SHALL go to S_IDLE, regs_o SHALL load REG_RESET, wr_strobe_o, err_o and spi_sdo_o SHALL be 0, and the bit counters and synchronizers SHALL clear.
REQ-026 Reset asserted mid-frame SHALL discard the frame; the bridge SHALL then wait for a fresh cs assertion before accepting a new frame.

Configuration
REQ-027 With SPI_BURST_EN defined, S_DATA SHALL loop after each DATA_WIDTH-bit word while cs stays asserted; each subsequent word SHALL target the address plus 1, wrapping modulo 2^ADDR_WIDTH, with reads and writes per REQ-018 to REQ-021 for each word.
REQ-028 Without SPI_BURST_EN, bits beyond FRAME_W SHALL be ignored in S_WAIT until cs is deasserted.

Structure
REQ-029 The package spi_reg_pkg SHALL hold the state enum, the FRAME_W calculation and the R/W bit constants.
REQ-030 The bridge SHALL instantiate the existing spi_dep_signal_synchronizer three times, for sck, sdi and cs; it SHALL have no other sub-module.

Verification (ADDR_WIDTH=7, DATA_WIDTH=8, REG_COUNT=4, STAT_COUNT=2)
REQ-031 Bench SHALL cover: write addr 2, data 0xA5 -> regs_o[23:16]=0xA5; wr_strobe_o=4'b0100 for exactly one cycle.
REQ-032 Bench SHALL cover: write 0x3C to addr 1, then read addr 1 -> sdo bits 0,0,1,1,1,1,0,0; no err_o.
REQ-033 Bench SHALL cover: status_i[7:0]=0x5A, read addr 4 -> 0x5A; write addr 5 -> regs unchanged, err_o one pulse; read addr 9 -> 0x00 plus err_o.
REQ-034 Bench SHALL cover: cs deasserted after 10 bits of a write -> no change, no strobe; the next full frame succeeds.
REQ-035 Bench SHALL cover: reset_i pulsed mid-frame -> regs_o=REG_RESET, FSM in S_IDLE; the remaining sck edges of that frame are ignored.
REQ-036 Bench SHALL cover: write addr 1, data 0x11, 0x22, 0x33 in one cs -> with SPI_BURST_EN, regs 1..3 hold 0x11, 0x22, 0x33; without it, only reg 1 = 0x11.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bridge: FSM state encoding,
// frame-length helper and the R/W command-bit values.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_WAIT
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // One R/W bit, then the address, then one data word.
  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_dep_signal_synchronizer.sv
// Two-flop synchronizer that brings one asynchronous pin into the clk_i domain.
module spi_dep_signal_synchronizer (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) sync_q <= '0;
    else         sync_q <= {sync_q[0], async_i};
  end

  assign sync_o = sync_q[1];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI (mode 0, MSB first) slave bridging to a bank of control registers and
// read-only status words. Define SPI_BURST_EN to allow auto-increment bursts.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int REG_COUNT  = 4,
  parameter int STAT_COUNT = 2,
  parameter logic [REG_COUNT*DATA_WIDTH-1:0] REG_RESET = '0
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             spi_sck_i,
  input  logic                             spi_sdi_i,
  input  logic                             spi_cs_i,
  output logic                             spi_sdo_o,
  output logic [REG_COUNT*DATA_WIDTH-1:0]  regs_o,
  output logic [REG_COUNT-1:0]             wr_strobe_o,
  input  logic [STAT_COUNT*DATA_WIDTH-1:0] status_i,
  output logic                             err_o
);

  localparam int FRAME_W = frame_w(ADDR_WIDTH, DATA_WIDTH);
  localparam int CMD_W   = 1 + ADDR_WIDTH;
  localparam int CNT_W   = $clog2(FRAME_W);

  logic sck_s, sdi_s, cs_n_s;

  spi_dep_signal_synchronizer u_sync_sck (.clk_i(clk_i), .reset_i(reset_i), .async_i(spi_sck_i), .sync_o(sck_s));
  spi_dep_signal_synchronizer u_sync_sdi (.clk_i(clk_i), .reset_i(reset_i), .async_i(spi_sdi_i), .sync_o(sdi_s));
  spi_dep_signal_synchronizer u_sync_cs  (.clk_i(clk_i), .reset_i(reset_i), .async_i(spi_cs_i),  .sync_o(cs_n_s));

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]           cmd_q, cmd_d;
  logic [DATA_WIDTH-2:0]           rx_q, rx_d;
  logic [DATA_WIDTH-1:0]           tx_q, tx_d;
  logic                            rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
  logic [REG_COUNT*DATA_WIDTH-1:0] regs_q, regs_d;
  logic [REG_COUNT-1:0]            strobe_q, strobe_d;
  logic                            err_q, err_d;
  logic                            sdo_q, sdo_d;
  logic                            sck_prev_q;
  logic                            armed_q, armed_d;

  logic                  sck_rise, sck_fall;
  logic [CMD_W-1:0]      cmd_full;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] lk_addr;
  logic [DATA_WIDTH-1:0] lk_word;
  logic                  lk_mapped;
  logic [REG_COUNT-1:0]  wr_onehot;

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cmd_full = {cmd_q, sdi_s};
  assign wdata    = {rx_q, sdi_s};
  // The snapshot address is the freshly received one, or the next word of a burst.
  assign lk_addr  = (state_q == S_CMD) ? cmd_full[ADDR_WIDTH-1:0] : addr_q + ADDR_WIDTH'(1);

  always_comb begin
    lk_word   = '0;
    lk_mapped = 1'b0;
    wr_onehot = '0;
    for (int k = 0; k < REG_COUNT; k++) begin
      if (lk_addr == ADDR_WIDTH'(k)) begin
        lk_word   = regs_q[k*DATA_WIDTH +: DATA_WIDTH];
        lk_mapped = 1'b1;
      end
      if (addr_q == ADDR_WIDTH'(k)) wr_onehot[k] = 1'b1;
    end
    for (int k = 0; k < STAT_COUNT; k++) begin
      if (lk_addr == ADDR_WIDTH'(REG_COUNT + k)) begin
        lk_word   = status_i[k*DATA_WIDTH +: DATA_WIDTH];
        lk_mapped = 1'b1;
      end
    end
  end

  // NOTE: every next-state signal gets its hold/default value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    regs_d   = regs_q;
    sdo_d    = 1'b0;
    strobe_d = '0;
    err_d    = 1'b0;
    armed_d  = armed_q | cs_n_s;

    if (cs_n_s) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Only a cs assertion seen after cs was high starts a frame.
          if (armed_q) begin
            state_d = S_CMD;
            cnt_d   = '0;
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            cmd_d = cmd_full[ADDR_WIDTH-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CMD_W - 1)) begin
              state_d = S_DATA;
              cnt_d   = '0;
              rw_d    = cmd_full[ADDR_WIDTH];
              addr_d  = lk_addr;
              tx_d    = lk_word;
              err_d   = (cmd_full[ADDR_WIDTH] == RW_READ) && !lk_mapped;
            end
          end
        end
        S_DATA: begin
          if (rw_q == RW_READ) begin
            sdo_d = sdo_q;
            if (sck_fall) begin
              sdo_d = tx_q[DATA_WIDTH-1];
              tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
          if (sck_rise) begin
            rx_d  = wdata[DATA_WIDTH-2:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              cnt_d = '0;
              if (rw_q == RW_WRITE) begin
                if (|wr_onehot) begin
                  strobe_d = wr_onehot;
                  for (int k = 0; k < REG_COUNT; k++) begin
                    if (wr_onehot[k]) regs_d[k*DATA_WIDTH +: DATA_WIDTH] = wdata;
                  end
                end else begin
                  err_d = 1'b1;
                end
              end
`ifdef SPI_BURST_EN
              addr_d = lk_addr;
              tx_d   = lk_word;
              if (rw_q == RW_READ && !lk_mapped) err_d = 1'b1;
`else
              state_d = S_WAIT;
              sdo_d   = 1'b0;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments; the register bank is reset because its reset value is architectural.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      rw_q       <= RW_WRITE;
      addr_q     <= '0;
      regs_q     <= REG_RESET;
      strobe_q   <= '0;
      err_q      <= 1'b0;
      sdo_q      <= 1'b0;
      sck_prev_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      regs_q     <= regs_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
      sdo_q      <= sdo_d;
      sck_prev_q <= sck_s;
      armed_q    <= armed_d;
    end
  end

  assign spi_sdo_o   = sdo_q;
  assign regs_o      = regs_q;
  assign wr_strobe_o = strobe_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: expected strobe/err events and read words
// are queued at issue time and popped by a monitor when the DUT produces them.
module tb_spi_reg_bridge;
  import spi_reg_pkg::*;

  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int RC   = 4;
  localparam int SC   = 2;
  localparam int FW   = AW + 1 + DW;
  localparam int HALF = 8;
  localparam logic [RC*DW-1:0] RST_VAL = 32'h0F1E2D3C;

  logic                 clk_i = 1'b0;
  logic                 reset_i;
  logic                 spi_sck_i, spi_sdi_i, spi_cs_i;
  logic                 spi_sdo_o;
  logic [RC*DW-1:0]     regs_o;
  logic [RC-1:0]        wr_strobe_o;
  logic [SC*DW-1:0]     status_i;
  logic                 err_o;

  spi_reg_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_COUNT(RC), .STAT_COUNT(SC), .REG_RESET(RST_VAL)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .spi_sck_i(spi_sck_i), .spi_sdi_i(spi_sdi_i), .spi_cs_i(spi_cs_i), .spi_sdo_o(spi_sdo_o),
    .regs_o(regs_o), .wr_strobe_o(wr_strobe_o), .status_i(status_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [RC-1:0]    strobe;
    logic             err;
    logic [RC*DW-1:0] regs;
  } evt_t;

  evt_t             exp_q[$];
  logic [DW-1:0]    rd_exp_q[$];
  logic             rd_valid = 1'b0;
  logic [DW-1:0]    rd_word = '0;
  logic [RC*DW-1:0] model_regs = RST_VAL;
  int               n_checks = 0;
  int               n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT pulses a strobe/err or a read word completes.
  always @(posedge clk_i) begin
    #1;
    if (!reset_i && (wr_strobe_o != '0 || err_o)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 64'({wr_strobe_o, err_o}), 64'(0));
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        check("wr_strobe", 64'(wr_strobe_o), 64'(e.strobe));
        check("err", 64'(err_o), 64'(e.err));
        check("regs_at_event", 64'(regs_o), 64'(e.regs));
      end
    end
    if (rd_valid) begin
      if (rd_exp_q.size() == 0) begin
        check("unexpected_read", 64'(rd_word), 64'(0));
        check("unexpected_read_flag", 64'(rd_valid), 64'(0));
      end else begin
        check("read_word", 64'(rd_word), 64'(rd_exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sck_cycle(input logic bit_in, output logic sampled);
    spi_sdi_i = bit_in;
    repeat (HALF) @(negedge clk_i);
    sampled = spi_sdo_o;
    spi_sck_i = 1'b1;
    repeat (HALF) @(negedge clk_i);
    spi_sck_i = 1'b0;
  endtask

  // Drives one cs frame; words in wwords are sent from the top byte down.
  task automatic spi_xfer(input logic rw, input int addr, input int nwords,
                          input logic [3*DW-1:0] wwords, input int max_bits);
    logic [AW:0]   cmd;
    logic [DW-1:0] wd, rd;
    logic          s;
    int            nb;
    cmd = {rw, AW'(addr)};
    nb  = 0;
    rd  = '0;
    spi_cs_i = 1'b0;
    for (int i = AW; i >= 0; i--) begin
      if (nb < max_bits) begin
        sck_cycle(cmd[i], s);
        nb++;
      end
    end
    for (int wi = 0; wi < nwords; wi++) begin
      wd = wwords[(2-wi)*DW +: DW];
      for (int b = DW - 1; b >= 0; b--) begin
        if (nb < max_bits) begin
          sck_cycle(wd[b], s);
          rd[b] = s;
          nb++;
        end
      end
      if (rw && nb == AW + 1 + (wi + 1) * DW) begin
        @(negedge clk_i);
        rd_word  = rd;
        rd_valid = 1'b1;
        @(negedge clk_i);
        rd_valid = 1'b0;
      end
    end
    repeat (HALF) @(negedge clk_i);
    spi_cs_i = 1'b1;
    repeat (2 * HALF) @(negedge clk_i);
  endtask

  task automatic expect_write(input int addr, input logic [DW-1:0] data);
    evt_t e;
    if (addr < RC) begin
      model_regs[addr*DW +: DW] = data;
      e.strobe = RC'(1) << addr;
      e.err    = 1'b0;
    end else begin
      e.strobe = '0;
      e.err    = 1'b1;
    end
    e.regs = model_regs;
    exp_q.push_back(e);
  endtask

  task automatic do_write(input int addr, input logic [DW-1:0] data);
    expect_write(addr, data);
    spi_xfer(RW_WRITE, addr, 1, {data, 16'h0}, FW);
  endtask

  task automatic do_read(input int addr, input logic [DW-1:0] exp_word);
    evt_t e;
    rd_exp_q.push_back(exp_word);
    if (addr >= RC + SC) begin
      e.strobe = '0;
      e.err    = 1'b1;
      e.regs   = model_regs;
      exp_q.push_back(e);
    end
    spi_xfer(RW_READ, addr, 1, '0, FW);
  endtask

  initial begin
    logic [AW:0]   cmd;
    logic [DW-1:0] wd;
    logic          s;
    reset_i   = 1'b1;
    spi_cs_i  = 1'b1;
    spi_sck_i = 1'b0;
    spi_sdi_i = 1'b0;
    status_i  = {8'hC3, 8'h5A};
    repeat (4) @(negedge clk_i);
    check("reset_regs", 64'(regs_o), 64'(RST_VAL));
    check("reset_strobe", 64'(wr_strobe_o), 64'(0));
    check("reset_err", 64'(err_o), 64'(0));
    check("reset_sdo", 64'(spi_sdo_o), 64'(0));
    check("reset_state", 64'(dut.state_q), 64'(S_IDLE));
    reset_i = 1'b0;
    repeat (4) @(negedge clk_i);

    // Single write to register 2.
    do_write(2, 8'hA5);
    check("reg2_after_write", 64'(regs_o[23:16]), 64'(8'hA5));

    // Write then read back register 1.
    do_write(1, 8'h3C);
    do_read(1, 8'h3C);

    // Status reads, status write error, unmapped read.
    do_read(4, 8'h5A);
    do_read(5, 8'hC3);
    do_write(5, 8'hFF);
    check("regs_after_status_write", 64'(regs_o), 64'(model_regs));
    do_read(9, 8'h00);
    do_read(2, 8'hA5);

    // Frame aborted after 10 bits, then a full frame.
    spi_xfer(RW_WRITE, 0, 1, {8'hEE, 16'h0}, 10);
    check("regs_after_abort", 64'(regs_o), 64'(model_regs));
    do_write(0, 8'h96);
    check("reg0_after_recovery", 64'(regs_o[7:0]), 64'(8'h96));

    // Reset pulsed mid-frame; the rest of the frame must be ignored.
    cmd = {RW_WRITE, 7'd3};
    wd  = 8'h5B;
    spi_cs_i = 1'b0;
    for (int i = AW; i >= 0; i--) sck_cycle(cmd[i], s);
    for (int b = DW - 1; b >= DW - 4; b--) sck_cycle(wd[b], s);
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    model_regs = RST_VAL;
    @(negedge clk_i);
    check("midframe_reset_regs", 64'(regs_o), 64'(RST_VAL));
    check("midframe_reset_state", 64'(dut.state_q), 64'(S_IDLE));
    for (int b = DW - 5; b >= 0; b--) sck_cycle(wd[b], s);
    repeat (2 * HALF) @(negedge clk_i);
    check("ignored_tail_state", 64'(dut.state_q), 64'(S_IDLE));
    check("ignored_tail_regs", 64'(regs_o), 64'(RST_VAL));
    spi_cs_i = 1'b1;
    repeat (2 * HALF) @(negedge clk_i);
    do_write(3, 8'h77);

    // Three words in one cs frame starting at register 1.
`ifdef SPI_BURST_EN
    expect_write(1, 8'h11);
    expect_write(2, 8'h22);
    expect_write(3, 8'h33);
`else
    expect_write(1, 8'h11);
`endif
    spi_xfer(RW_WRITE, 1, 3, 24'h112233, AW + 1 + 3 * DW);
    check("regs_after_multiword", 64'(regs_o), 64'(model_regs));
    check("reg1_after_multiword", 64'(regs_o[15:8]), 64'(8'h11));

    repeat (4 * HALF) @(negedge clk_i);
    check("events_outstanding", 64'(exp_q.size()), 64'(0));
    check("reads_outstanding", 64'(rd_exp_q.size()), 64'(0));
    check("sdo_idle", 64'(spi_sdo_o), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
